cache_mrp_assoc: RTL

//  N-way set-associative must-read-protected cache. A written entry is protected until a read

---
 rtl/cache_mrp_assoc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cache_mrp_assoc.sv
// Set-associative must-read-protected cache: a written entry cannot be replaced until
// a read has consumed it. Responses are registered one cycle after the sampled op.
module cache_mrp_assoc #(
   parameter  int IDX_BITS   = 2,
   parameter  int WAYS       = 2,
   parameter  int DATA_WIDTH = 16,
   parameter  int ADDR_WIDTH = 8,
   localparam int NUM_SETS   = 2 ** IDX_BITS,
   localparam int TAG_W      = ADDR_WIDTH - IDX_BITS,
   localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int PEND_W     = $clog2(NUM_SETS * WAYS + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  ce_i,
   input  logic                  we_i,
   input  logic                  flush_i,
   output logic                  resp_vld_o,
   output logic                  rhit_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  wack_o,
   output logic [WAY_W-1:0]      way_o,
   output logic [PEND_W-1:0]     pending_o
);

   // Per-entry state; valid/consumed need reset and flush, tag/data do not.
   logic                  valid_reg    [NUM_SETS][WAYS];
   logic                  consumed_reg [NUM_SETS][WAYS];
   logic [TAG_W-1:0]      tag_reg      [NUM_SETS][WAYS];
   logic [DATA_WIDTH-1:0] data_reg     [NUM_SETS][WAYS];

   logic                  armed_reg;
   logic                  resp_vld_reg;
   logic                  rhit_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  wack_reg;
   logic [WAY_W-1:0]      way_reg;
   logic [PEND_W-1:0]     pending_reg;

   logic [IDX_BITS-1:0]   idx;
   logic [TAG_W-1:0]      tag;
   logic [WAYS-1:0]       match;
   logic [WAYS-1:0]       free;
   logic [WAYS-1:0]       spent;

   assign idx = addr_i[IDX_BITS-1:0];
   assign tag = addr_i[ADDR_WIDTH-1:IDX_BITS];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign match[gi] = valid_reg[idx][gi] && (tag_reg[idx][gi] == tag);
         assign free[gi]  = !valid_reg[idx][gi];
         assign spent[gi] = valid_reg[idx][gi] && consumed_reg[idx][gi];
      end
   endgenerate

   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             free_any;
   logic [WAY_W-1:0] free_way;
   logic             spent_any;
   logic [WAY_W-1:0] spent_way;

   // Downward scans so the lowest-index candidate is the one that sticks.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      free_any  = 1'b0;
      free_way  = '0;
      spent_any = 1'b0;
      spent_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (free[w]) begin
            free_any = 1'b1;
            free_way = WAY_W'(w);
         end
         if (spent[w]) begin
            spent_any = 1'b1;
            spent_way = WAY_W'(w);
         end
      end
   end

   logic             op_go;
   logic             wr_accept;
   logic [WAY_W-1:0] victim;
   logic             hit_unconsumed;

   assign op_go          = armed_reg && ce_i && !flush_i;
   assign hit_unconsumed = hit && !consumed_reg[idx][hit_way];

   // A matching tag always decides the write, so a set never holds duplicate tags.
   always_comb begin
      wr_accept = 1'b0;
      victim    = '0;
      if (hit) begin
         wr_accept = !hit_unconsumed;
         victim    = hit_unconsumed ? '0 : hit_way;
      end else if (free_any) begin
         wr_accept = 1'b1;
         victim    = free_way;
      end else if (spent_any) begin
         wr_accept = 1'b1;
         victim    = spent_way;
      end
   end

   logic do_write;
   logic do_read;

   assign do_write = op_go && we_i && wr_accept;
   assign do_read  = op_go && !we_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_reg[s][w]    <= 1'b0;
               consumed_reg[s][w] <= 1'b1;
            end
         end
         armed_reg    <= 1'b0;
         resp_vld_reg <= 1'b0;
         rhit_reg     <= 1'b0;
         rdata_reg    <= '0;
         wack_reg     <= 1'b0;
         way_reg      <= '0;
         pending_reg  <= '0;
      end else begin
         armed_reg    <= 1'b1;
         resp_vld_reg <= op_go;
         rhit_reg     <= 1'b0;
         rdata_reg    <= '0;
         wack_reg     <= 1'b0;
         way_reg      <= '0;
         if (flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               for (int w = 0; w < WAYS; w++) begin
                  valid_reg[s][w]    <= 1'b0;
                  consumed_reg[s][w] <= 1'b1;
               end
            end
            pending_reg <= '0;
         end else if (do_write) begin
            valid_reg[idx][victim]    <= 1'b1;
            consumed_reg[idx][victim] <= 1'b0;
            wack_reg                  <= 1'b1;
            way_reg                   <= victim;
            // Victims are always free or consumed, so the count cannot exceed capacity.
            pending_reg               <= pending_reg + PEND_W'(1);
         end else if (do_read && hit) begin
            consumed_reg[idx][hit_way] <= 1'b1;
            rhit_reg                   <= 1'b1;
            rdata_reg                  <= data_reg[idx][hit_way];
            way_reg                    <= hit_way;
            if (hit_unconsumed) begin
               pending_reg <= pending_reg - PEND_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         tag_reg[idx][victim]  <= tag;
         data_reg[idx][victim] <= wdata_i;
      end
   end

   assign resp_vld_o = resp_vld_reg;
   assign rhit_o     = rhit_reg;
   assign rdata_o    = rdata_reg;
   assign wack_o     = wack_reg;
   assign way_o      = way_reg;
   assign pending_o  = pending_reg;

endmodule
